// File: rtl/tx_mac_ifm_packer_pkg.sv
// ---------------------------------------------------------------------------
// tx_mac_ifm_packer_pkg
// Shared constants and payload type for the IFM packer that feeds the MAC
// array IFM port.
//   TX_MAC_W_ELEMENT    : element width in bits
//   TX_MAC_LANES        : elements per MAC IFM transaction
//   TX_MAC_IFM_IN_LANES : elements per fetch-side input beat
//   TX_MAC_IFM_BEATS    : input beats per full transaction
//   tx_mac_ifm_port_t   : MAC IFM transaction (data, per-lane valid, tags)
// ---------------------------------------------------------------------------
package tx_mac_ifm_packer_pkg;

    localparam int TX_MAC_W_ELEMENT    = 9;
    localparam int TX_MAC_LANES        = 64;
    localparam int TX_MAC_IFM_IN_LANES = 16;
    localparam int TX_MAC_IFM_BEATS    = TX_MAC_LANES / TX_MAC_IFM_IN_LANES;

    // Field order here is also the bit order of the packed FIFO payload.
    typedef struct packed {
        logic [TX_MAC_LANES*TX_MAC_W_ELEMENT-1:0] data;
        logic [TX_MAC_LANES-1:0]                  data_element_valid;
        logic                                     inter_end;
        logic                                     accum_end;
    } tx_mac_ifm_port_t;

    // Width of one packed transaction for arbitrary lane count / element width.
    function automatic int ifm_port_width(input int elem_w, input int lanes);
        return lanes * elem_w + lanes + 2;
    endfunction

endpackage

// File: rtl/tx_mac_ifm_packer_if.sv
// ---------------------------------------------------------------------------
// tx_mac_ifm_packer_if
// Bundles the fetch-side beat handshake and the MAC-side transaction
// handshake of the IFM packer.
//   master : fetch path / MAC side (drives i_*, o_ready)
//   slave  : the packer (drives i_ready, o_*)
// ---------------------------------------------------------------------------
interface tx_mac_ifm_packer_if #(
    parameter int ELEM_W   = 9,
    parameter int LANES    = 64,
    parameter int IN_LANES = 16,
    parameter int DEPTH    = 2
);
    logic                          i_valid;
    logic                          i_ready;
    logic [IN_LANES*ELEM_W-1:0]    i_data;
    logic [IN_LANES-1:0]           i_elem_valid;
    logic                          i_inter_end;
    logic                          i_accum_end;

    logic                          o_valid;
    logic                          o_ready;
    logic [LANES*ELEM_W-1:0]       o_data;
    logic [LANES-1:0]              o_elem_valid;
    logic                          o_inter_end;
    logic                          o_accum_end;
    logic                          o_partial;
    logic [$clog2(DEPTH+1)-1:0]    o_fifo_count;

    modport master (
        output i_valid, i_data, i_elem_valid, i_inter_end, i_accum_end, o_ready,
        input  i_ready, o_valid, o_data, o_elem_valid, o_inter_end, o_accum_end,
               o_partial, o_fifo_count
    );

    modport slave (
        input  i_valid, i_data, i_elem_valid, i_inter_end, i_accum_end, o_ready,
        output i_ready, o_valid, o_data, o_elem_valid, o_inter_end, o_accum_end,
               o_partial, o_fifo_count
    );
endinterface

// File: rtl/tx_sync_fifo.sv
// ---------------------------------------------------------------------------
// tx_sync_fifo
// Small single-clock FIFO. Head data and occupancy come straight from
// registers, so nothing on the read side depends combinationally on push/pop.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (ignored when full)
//   pop        : drop head entry (ignored when empty)
//   head_data  : current head entry
//   head_valid : FIFO not empty
//   count      : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head_data,
    output logic                        head_valid,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    assign push_ok = push && (count_reg < CNT_W'(DEPTH));
    assign pop_ok  = pop && (count_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data  = mem_reg[rd_ptr_reg];
    assign head_valid = (count_reg != '0);
    assign count      = count_reg;

endmodule

// File: rtl/tx_mac_ifm_packer.sv
// ---------------------------------------------------------------------------
// tx_mac_ifm_packer
// Packs IN_LANES-wide IFM beats into LANES-wide MAC IFM transactions and
// buffers finished transactions in a DEPTH-entry FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of tx_mac_ifm_packer_if
//              i_valid/i_ready/i_data/i_elem_valid/i_inter_end/i_accum_end
//              o_valid/o_ready/o_data/o_elem_valid/o_inter_end/o_accum_end
//              o_partial (open assembly), o_fifo_count (FIFO occupancy)
// A transaction closes on the last slot, on inter_end or on accum_end;
// accum_end alone also implies inter_end on the output.
// ---------------------------------------------------------------------------
module tx_mac_ifm_packer
    import tx_mac_ifm_packer_pkg::*;
#(
    parameter int ELEM_W   = TX_MAC_W_ELEMENT,
    parameter int LANES    = TX_MAC_LANES,
    parameter int IN_LANES = TX_MAC_IFM_IN_LANES,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    tx_mac_ifm_packer_if.slave  bus
);
    localparam int BEATS     = LANES / IN_LANES;
    localparam int PTR_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SLOT_W    = IN_LANES * ELEM_W;
    localparam int PAYLOAD_W = ifm_port_width(ELEM_W, LANES);
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BEATS - 1);

    logic [PTR_W-1:0]        ptr_reg, ptr_next;
    logic                    partial_reg, partial_next;
    logic [LANES*ELEM_W-1:0] asm_data_reg, asm_data_next;
    logic [LANES-1:0]        asm_ev_reg, asm_ev_next;
    logic [SLOT_W-1:0]       beat_data_masked;
    logic                    accept;
    logic                    close_beat;
    logic                    tag_inter;
    logic                    fifo_valid;
    logic                    fifo_pop;
    logic [CNT_W-1:0]        fifo_count;
    logic [PAYLOAD_W-1:0]    push_payload;
    logic [PAYLOAD_W-1:0]    head_payload;

    // i_ready depends only on the registered FIFO count, never on o_ready.
    assign bus.i_ready = (fifo_count < CNT_W'(DEPTH));
    assign accept      = bus.i_valid && bus.i_ready;
    assign close_beat  = accept && ((ptr_reg == LAST_PTR) || bus.i_inter_end || bus.i_accum_end);
    assign tag_inter   = bus.i_inter_end || bus.i_accum_end;

    // Invalid elements are stored as zero so they never carry stale data.
    generate
        for (genvar gi = 0; gi < IN_LANES; gi++) begin : g_mask
            assign beat_data_masked[gi*ELEM_W +: ELEM_W] =
                bus.i_elem_valid[gi] ? bus.i_data[gi*ELEM_W +: ELEM_W] : '0;
        end
    endgenerate

    // Next assembly image: the addressed slot takes the beat; the first beat
    // of a transaction wipes every other slot, later beats keep them.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
            logic slot_sel;
            logic first_beat;
            assign slot_sel   = (ptr_reg == PTR_W'(gi));
            assign first_beat = (ptr_reg == '0);
            assign asm_data_next[gi*SLOT_W +: SLOT_W] =
                slot_sel   ? beat_data_masked :
                first_beat ? '0 : asm_data_reg[gi*SLOT_W +: SLOT_W];
            assign asm_ev_next[gi*IN_LANES +: IN_LANES] =
                slot_sel   ? bus.i_elem_valid :
                first_beat ? '0 : asm_ev_reg[gi*IN_LANES +: IN_LANES];
        end
    endgenerate

    always_comb begin
        ptr_next     = ptr_reg;
        partial_next = partial_reg;
        if (close_beat) begin
            ptr_next     = '0;
            partial_next = 1'b0;
        end else if (accept) begin
            ptr_next     = ptr_reg + 1'b1;
            partial_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg      <= '0;
            partial_reg  <= 1'b0;
            asm_data_reg <= '0;
            asm_ev_reg   <= '0;
        end else begin
            ptr_reg     <= ptr_next;
            partial_reg <= partial_next;
            if (accept) begin
                asm_data_reg <= asm_data_next;
                asm_ev_reg   <= asm_ev_next;
            end
        end
    end

    // Same bit order as tx_mac_ifm_port_t.
    assign push_payload = {asm_data_next, asm_ev_next, tag_inter, bus.i_accum_end};
    assign fifo_pop     = fifo_valid && bus.o_ready;

    tx_sync_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (close_beat),
        .push_data  (push_payload),
        .pop        (fifo_pop),
        .head_data  (head_payload),
        .head_valid (fifo_valid),
        .count      (fifo_count)
    );

    assign bus.o_valid = fifo_valid;
    assign {bus.o_data, bus.o_elem_valid, bus.o_inter_end, bus.o_accum_end} = head_payload;
    assign bus.o_partial    = partial_reg;
    assign bus.o_fifo_count = fifo_count;

endmodule

// File: tb/tb_tx_mac_ifm_packer.sv
// ---------------------------------------------------------------------------
// tb_tx_mac_ifm_packer
// Directed table of transactions, FIFO back-pressure and reset sequences,
// then a random run against a reference scoreboard.
// ---------------------------------------------------------------------------
module tb_tx_mac_ifm_packer;
    import tx_mac_ifm_packer_pkg::*;

    localparam int EW = 9;
    localparam int LN = 64;
    localparam int IL = 16;
    localparam int DP = 2;
    localparam int BT = TX_MAC_IFM_BEATS;
    localparam int IW = IL * EW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_mac_ifm_packer_if #(.ELEM_W(EW), .LANES(LN), .IN_LANES(IL), .DEPTH(DP)) bus ();

    tx_mac_ifm_packer #(.ELEM_W(EW), .LANES(LN), .IN_LANES(IL), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    tx_mac_ifm_port_t exp_q[$];
    tx_mac_ifm_port_t mon_t;
    logic [LN*EW-1:0] m_data;
    logic [LN-1:0]    m_ev;
    int               m_ptr;

    typedef struct {
        int          nbeats;
        logic [15:0] ev;
        logic        all_ones;
        logic [8:0]  seed;
        logic        ie;
        logic        ae;
        logic [63:0] exp_ev;
        logic        exp_ie;
        logic        exp_ae;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] make_beat(input logic [8:0] seed, input logic all_ones);
        logic [IW-1:0] d;
        for (int e = 0; e < IL; e++) begin
            d[e*EW +: EW] = all_ones ? 9'h1FF : seed + 9'(e);
        end
        return d;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_data = '0;
        m_ev   = '0;
        exp_q.delete();
    endtask

    // Reference assembly: what the MAC should see for the accepted beats.
    task automatic model_accept(input logic [IW-1:0] d, input logic [15:0] ev,
                                input logic ie, input logic ae);
        tx_mac_ifm_port_t t;
        if (m_ptr == 0) begin
            m_data = '0;
            m_ev   = '0;
        end
        for (int e = 0; e < IL; e++) begin
            if (ev[e]) begin
                m_data[(m_ptr*IL + e)*EW +: EW] = d[e*EW +: EW];
                m_ev[m_ptr*IL + e] = 1'b1;
            end
        end
        if (m_ptr == BT-1 || ie || ae) begin
            t.data               = m_data;
            t.data_element_valid = m_ev;
            t.inter_end          = ie | ae;
            t.accum_end          = ae;
            exp_q.push_back(t);
            m_ptr = 0;
        end else begin
            m_ptr++;
        end
    endtask

    // Called at #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_beat(input logic [IW-1:0] d, input logic [15:0] ev,
                             input logic ie, input logic ae);
        int waited = 0;
        bus.i_valid      = 1'b1;
        bus.i_data       = d;
        bus.i_elem_valid = ev;
        bus.i_inter_end  = ie;
        bus.i_accum_end  = ae;
        while (!bus.i_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got i_ready=0 for 100 cycles, required 1");
            bus.i_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            bus.i_valid     = 1'b0;
            bus.i_inter_end = 1'b0;
            bus.i_accum_end = 1'b0;
            model_accept(d, ev, ie, ae);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic last;
        for (int b = 0; b < v.nbeats; b++) begin
            last = (b == v.nbeats - 1);
            send_beat(make_beat(v.seed + 9'(b*16), v.all_ones), v.ev, last & v.ie, last & v.ae);
            if (!last)
                check($sformatf("v%0d_partial_b%0d", idx, b), 640'(bus.o_partial), 640'(1));
        end
        check($sformatf("v%0d_o_valid", idx), 640'(bus.o_valid), 640'(1));
        check($sformatf("v%0d_elem_valid", idx), 640'(bus.o_elem_valid), 640'(v.exp_ev));
        check($sformatf("v%0d_inter_end", idx), 640'(bus.o_inter_end), 640'(v.exp_ie));
        check($sformatf("v%0d_accum_end", idx), 640'(bus.o_accum_end), 640'(v.exp_ae));
        check($sformatf("v%0d_partial_closed", idx), 640'(bus.o_partial), 640'(0));
    endtask

    // Scoreboard: every popped transaction is compared with the reference queue.
    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.o_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got elem_valid=%h, expected no transaction", bus.o_elem_valid);
            end else begin
                mon_t = exp_q.pop_front();
                check("pop_data", 640'(bus.o_data), 640'(mon_t.data));
                check("pop_elem_valid", 640'(bus.o_elem_valid), 640'(mon_t.data_element_valid));
                check("pop_tags", 640'({bus.o_inter_end, bus.o_accum_end}),
                      640'({mon_t.inter_end, mon_t.accum_end}));
                n_txn++;
                $display("txn %0d: elem_valid=%h inter_end=%b accum_end=%b",
                         n_txn, bus.o_elem_valid, bus.o_inter_end, bus.o_accum_end);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v5;
        int beats, cycles, w;
        logic pend, pv, pr;
        logic [IW-1:0] pd;
        logic [15:0] pev;
        logic pie, pae;

        vecs[0] = '{4, 16'hFFFF, 1'b0, 9'h001, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[1] = '{2, 16'hFFFF, 1'b0, 9'h040, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{1, 16'h00FF, 1'b1, 9'h000, 1'b0, 1'b1, 64'h0000_0000_0000_00FF, 1'b1, 1'b1};
        vecs[3] = '{4, 16'hFFFF, 1'b0, 9'h080, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[4] = '{3, 16'h0F0F, 1'b0, 9'h007, 1'b1, 1'b1, 64'h0000_0F0F_0F0F_0F0F, 1'b1, 1'b1};
        vecs[5] = '{1, 16'h8001, 1'b0, 9'h1F0, 1'b1, 1'b0, 64'h0000_0000_0000_8001, 1'b1, 1'b0};

        rst              = 1'b1;
        bus.i_valid      = 1'b0;
        bus.i_data       = '0;
        bus.i_elem_valid = '0;
        bus.i_inter_end  = 1'b0;
        bus.i_accum_end  = 1'b0;
        bus.o_ready      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_i_ready", 640'(bus.i_ready), 640'(1));
        check("rst_o_valid", 640'(bus.o_valid), 640'(0));
        check("rst_o_partial", 640'(bus.o_partial), 640'(0));
        check("rst_fifo_count", 640'(bus.o_fifo_count), 640'(0));
        check("rst_o_data", 640'(bus.o_data), 640'(0));
        check("rst_o_elem_valid", 640'(bus.o_elem_valid), 640'(0));
        check("rst_tags", 640'({bus.o_inter_end, bus.o_accum_end}), 640'(0));
        rst = 1'b0;

        // Directed table, MAC always ready
        bus.o_ready = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
        @(posedge clk); #1;

        // Back-pressure: DEPTH=2 with three single-beat transactions
        bus.o_ready = 1'b0;
        check("bp_start_count", 640'(bus.o_fifo_count), 640'(0));
        send_beat(make_beat(9'h100, 1'b0), 16'hFFFF, 1'b1, 1'b0);
        check("bp_count1", 640'(bus.o_fifo_count), 640'(1));
        check("bp_ready1", 640'(bus.i_ready), 640'(1));
        send_beat(make_beat(9'h120, 1'b0), 16'h0F0F, 1'b1, 1'b0);
        check("bp_count2", 640'(bus.o_fifo_count), 640'(2));
        check("bp_ready_full", 640'(bus.i_ready), 640'(0));
        check("bp_head_data", 640'(bus.o_data), 640'(exp_q[0].data));
        bus.i_valid      = 1'b1;
        bus.i_data       = make_beat(9'h140, 1'b0);
        bus.i_elem_valid = 16'hF000;
        bus.i_inter_end  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_stall_ready_c%0d", c), 640'(bus.i_ready), 640'(0));
            check($sformatf("bp_stall_count_c%0d", c), 640'(bus.o_fifo_count), 640'(2));
            check($sformatf("bp_stall_partial_c%0d", c), 640'(bus.o_partial), 640'(0));
            check($sformatf("bp_head_hold_c%0d", c), 640'(bus.o_elem_valid), 640'(64'hFFFF));
        end
        bus.o_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_pop1_count", 640'(bus.o_fifo_count), 640'(1));
        check("bp_pop1_ready", 640'(bus.i_ready), 640'(1));
        check("bp_pop1_head", 640'(bus.o_elem_valid), 640'(64'h0F0F));
        @(posedge clk); #1;
        model_accept(make_beat(9'h140, 1'b0), 16'hF000, 1'b1, 1'b0);
        bus.i_valid     = 1'b0;
        bus.i_inter_end = 1'b0;
        check("bp_third_count", 640'(bus.o_fifo_count), 640'(1));
        check("bp_third_head", 640'(bus.o_elem_valid), 640'(64'hF000));
        @(posedge clk); #1;
        check("bp_drained", 640'({bus.o_valid, bus.o_fifo_count}), 640'(0));

        // Reset in the middle of an assembly
        for (int b = 0; b < 3; b++)
            send_beat(make_beat(9'h010 + 9'(b*16), 1'b0), 16'hFFFF, 1'b0, 1'b0);
        check("mid_partial", 640'(bus.o_partial), 640'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_o_valid", 640'(bus.o_valid), 640'(0));
        check("mid_rst_partial", 640'(bus.o_partial), 640'(0));
        check("mid_rst_count", 640'(bus.o_fifo_count), 640'(0));
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        v5 = '{4, 16'hFFFF, 1'b0, 9'h0A0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        run_vec(v5, 6);
        @(posedge clk); #1;

        // Random traffic against the scoreboard
        beats  = 0;
        cycles = 0;
        pend   = 1'b0;
        pv     = 1'b0;
        pr     = 1'b0;
        pd     = '0;
        pev    = '0;
        pie    = 1'b0;
        pae    = 1'b0;
        while (beats < 1000 && cycles < 20000) begin
            @(posedge clk); #1;
            cycles++;
            if (pv && pr) begin
                model_accept(pd, pev, pie, pae);
                beats++;
                pend = 1'b0;
            end
            bus.o_ready = 1'($urandom_range(0, 1));
            if (!pend && beats < 1000 && $urandom_range(0, 1) == 1) begin
                for (int e = 0; e < IL; e++) pd[e*EW +: EW] = 9'($urandom);
                pev  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                pie  = ($urandom_range(0, 4) == 0);
                pae  = ($urandom_range(0, 9) == 0);
                pend = 1'b1;
            end
            bus.i_valid      = pend;
            bus.i_data       = pd;
            bus.i_elem_valid = pev;
            bus.i_inter_end  = pie;
            bus.i_accum_end  = pae;
            pv = bus.i_valid;
            pr = bus.i_ready;
        end
        bus.i_valid = 1'b0;
        check("random_beats_done", 640'(beats), 640'(1000));
        bus.o_ready = 1'b1;
        if (m_ptr != 0) send_beat(make_beat(9'h055, 1'b0), 16'hFFFF, 1'b1, 1'b0);
        w = 0;
        while ((exp_q.size() != 0 || bus.o_valid) && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("final_queue_empty", 640'(exp_q.size()), 640'(0));
        check("final_fifo_empty", 640'({bus.o_valid, bus.o_fifo_count}), 640'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
